pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor with carry-out and signed overflow.
//   Generalises the 32-bit ripple adder: configurable width, a per-transaction add/sub mode, and
//   STAGES pipeline slices with a valid/ready handshake.
//   Sits between operand-fetch and result-writeback in the adder datapath; one result per cycle when unstalled.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be >= 2
//   STAGES  4   pipeline depth = number of carry slices; WIDTH % STAGES == 0 (elaboration error otherwise)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/sub valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      0: S = a + b; 1: S = a - b
//   out_valid  out  1      S/carry/overflow valid
//   out_ready  in   1      downstream accepts the result
//   S          out  WIDTH  sum/difference, modulo 2^WIDTH
//   carry      out  1      carry-out of MSB (sub: 1 = no borrow, i.e. a >= b unsigned)
//   overflow   out  1      signed overflow of the selected operation
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous): all stage valid flags clear; out_valid, S, carry, overflow = 0.
//     In-flight operations are discarded; the first accept after release is a fresh transaction.
//   - Arithmetic: b_eff = sub ? ~b : b; cin = sub. Slice k (k = 0..STAGES-1) adds bits
//     [k*W/S +: W/S] of a and b_eff with the carry registered from slice k-1 (slice 0 uses cin).
//     Higher operand slices are delayed in skew registers; completed result slices are carried forward.
//   - overflow = (a[MSB] == b_eff[MSB]) && (S[MSB] != a[MSB]); carry = carry-out of top slice.
//   - Latency: exactly STAGES cycles from accept (in_valid && in_ready) to out_valid, with no stall.
//   - Throughput: one transaction per cycle while out_ready stays high.
//   - Handshake, per stage i with valid v[i]: ready[i] = !v[i] || ready[i+1]; ready[STAGES] = out_ready;
//     in_ready = ready[0]. A stage loads only when its ready is high, and holds its contents otherwise.
//     Bubbles are squeezed out under backpressure.
//   - Outputs are stable while out_valid && !out_ready (no change to S/carry/overflow).
//   - Simultaneous accept and emit in the same cycle is legal and loses no data.
//   - in_ready does not depend on in_valid. It may depend combinationally on out_ready.
//   - Wrap-around: results are mod 2^WIDTH; carry/overflow are the only range indicators.
//   - STAGES == 1 degenerates to one registered full-width add with 1-cycle latency.
// STRUCTURE
//   - Package adder_pkg: mode constants OP_ADD = 1'b0, OP_SUB = 1'b1; function slice_w(WIDTH, STAGES).
//   - Sub-module addsub_slice: combinational W/S-bit add with cin/cout plus its output register and
//     valid/ready logic. Instantiated STAGES times in a generate loop.
//   - Top: b inversion, skew/deskew registers, overflow computation on the final stage.
// TESTING
//   1. W=32,S=4, sub=0: a=0x7FFFFFFF, b=0x00000001 -> after 4 clk: S=0x80000000, carry=0, overflow=1.
//   2. sub=0: a=0xFFFFFFFF, b=0x00000001 -> S=0x00000000, carry=1, overflow=0 (unsigned wrap).
//   3. sub=1: a=5, b=7 -> S=0xFFFFFFFE, carry=0, overflow=0.
//      sub=1: a=0x80000000, b=1 -> S=0x7FFFFFFF, carry=1, overflow=1.
//   4. Stream 10 back-to-back adds (a=i, b=i<<16), out_ready=1 -> 10 results on consecutive cycles,
//      in order, first at cycle 4.
//   5. Stream with out_ready low for 6 cycles mid-stream -> in_ready drops after pipeline fills,
//      outputs held stable, no loss or duplication.
//   6. Assert rst_n low with 3 ops in flight -> out_valid=0 immediately.
//      After release, a new op (a=1, b=2) yields S=3 only; no stale results.
//   Sweep: random a/b/sub vs. reference model for (W,S) in {(32,4),(8,1),(64,8),(16,2)}.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor datapath.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits handled by each carry slice.
  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry slice: adds its SW-bit window, merges it into the partial result and
// registers operands, partial sum and carry for the next slice.
module addsub_slice #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_in,
  input  logic             ready_next,
  output logic             ready_c,
  output logic             v,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q,
  output logic             c_q,
  output logic             ovf_q
);

  localparam int unsigned LSB = IDX * SW;

  logic [SW:0]      sum;
  logic [WIDTH-1:0] s_next;
  logic             ovf_next;

  // Slice add; the overflow term is only meaningful in the top slice.
  always_comb begin
    sum              = {1'b0, a_in[LSB +: SW]} + {1'b0, b_in[LSB +: SW]} + (SW+1)'(c_in);
    s_next           = s_in;
    s_next[LSB +: SW] = sum[SW-1:0];
    ovf_next         = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_next[WIDTH-1] != a_in[WIDTH-1]);
  end

  assign ready_c = !v || ready_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (ready_c) begin
      v <= v_in;
      if (v_in) begin
        a_q   <= a_in;
        b_q   <= b_in;
        s_q   <= s_next;
        c_q   <= sum[SW];
        ovf_q <= ovf_next;
      end
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: STAGES carry slices with a
// valid/ready handshake, carry-out and signed overflow.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Index 0 is the pipeline input; index k+1 is the register of slice k.
  logic [STAGES:0]            v;
  logic [STAGES:0]            c_p;
  logic [STAGES:0]            o_p;
  logic [STAGES:0][WIDTH-1:0] a_p;
  logic [STAGES:0][WIDTH-1:0] b_p;
  logic [STAGES:0][WIDTH-1:0] s_p;
  logic [STAGES-1:0]          rdy;
  logic [STAGES-1:0]          nxt;
  logic                       unused_sink;

  assign v[0]   = in_valid;
  assign a_p[0] = a;
  assign b_p[0] = (sub == OP_SUB) ? ~b : b;
  assign s_p[0] = '0;
  assign c_p[0] = sub;
  assign o_p[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Downstream readiness unrolled so no ready bit depends on another ready bit.
    if (k == STAGES - 1) begin : g_last
      assign nxt[k] = out_ready;
    end else begin : g_mid
      assign nxt[k] = out_ready || !(&v[STAGES:k+2]);
    end

    addsub_slice #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .v_in       (v[k]),
      .ready_next (nxt[k]),
      .ready_c    (rdy[k]),
      .v          (v[k+1]),
      .a_in       (a_p[k]),
      .b_in       (b_p[k]),
      .s_in       (s_p[k]),
      .c_in       (c_p[k]),
      .a_q        (a_p[k+1]),
      .b_q        (b_p[k+1]),
      .s_q        (s_p[k+1]),
      .c_q        (c_p[k+1]),
      .ovf_q      (o_p[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES];
  assign S         = s_p[STAGES];
  assign carry     = c_p[STAGES];
  assign overflow  = o_p[STAGES];

  assign unused_sink = ^{a_p[STAGES], b_p[STAGES], o_p[STAGES-1:0], rdy};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         carry;
  logic         overflow;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .carry     (carry),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           pops = 0;
  int           first_pop = -1;
  int           last_pop = -1;
  bit           lat_mode = 1'b0;
  bit           use_exp = 1'b0;
  bit           acc = 1'b0;
  bit           held = 1'b0;
  logic [W-1:0] exp_s, held_s;
  logic         exp_c, exp_o, held_c, held_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-width behavioural reference.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] be;
    logic [W:0]   r;
    exp_t         e;
    be    = s ? ~y : y;
    r     = {1'b0, x} + {1'b0, be} + (W+1)'(s);
    e.s   = r[W-1:0];
    e.c   = r[W];
    e.o   = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
    e.cyc = 0;
    return e;
  endfunction

  // One clock: sample handshakes at negedge, score, then advance past the edge.
  task automatic step();
    exp_t e;
    exp_t g;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (held) begin
      chk("hold_S", 64'(S), 64'(held_s));
      chk("hold_carry", 64'(carry), 64'(held_c));
      chk("hold_overflow", 64'(overflow), 64'(held_o));
    end
    if (out_valid && out_ready) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        g = sb.pop_front();
        chk("S", 64'(S), 64'(g.s));
        chk("carry", 64'(carry), 64'(g.c));
        chk("overflow", 64'(overflow), 64'(g.o));
        if (lat_mode) chk("latency", 64'(cyc - g.cyc), 64'(N));
      end
    end
    held   = out_valid && !out_ready;
    held_s = S;
    held_c = carry;
    held_o = overflow;
    if (acc) begin
      if (use_exp) begin
        e.s = exp_s; e.c = exp_c; e.o = exp_o;
      end else begin
        e = model(a, b, sub);
      end
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input bit ue, input logic [W-1:0] es, input logic ec, input logic eo);
    bit done;
    done = 1'b0;
    use_exp = ue; exp_s = es; exp_c = ec; exp_o = eo;
    in_valid = 1'b1; a = x; b = y; sub = s; out_ready = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      step();
      if (acc) done = 1'b1;
    end
    chk("accept_timeout", 64'(done), 64'(1));
    in_valid = 1'b0;
    use_exp = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && sb.size() != 0; t++) step();
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Stream n adds (a=i, b=i<<16); out_ready low for sl cycles from cycle st.
  task automatic run(input int n, input int st, input int sl, output int c0);
    int i;
    int t;
    i = 0; t = 0; c0 = cyc; pops = 0; first_pop = -1;
    while (i < n && t < 200) begin
      in_valid = 1'b1; a = W'(i); b = W'(i) << 16; sub = 1'b0;
      out_ready = !(t >= st && t < st + sl);
      #1;
      if (sl > 0 && t == st + sl - 1) chk("in_ready_stalled", 64'(in_ready), 64'(0));
      step();
      if (acc) i++;
      t++;
    end
    in_valid = 1'b0;
    chk("stream_accepts", 64'(i), 64'(n));
    drain();
    chk("stream_outputs", 64'(pops), 64'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_S", 64'(S), 64'(0));
    chk("reset_carry", 64'(carry), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic corners with fixed expectations.
    lat_mode = 1'b1;
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1); drain();
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0); drain();
    send(32'd5,        32'd7,        1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0); drain();
    send(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1); drain();

    // Back-to-back stream, no backpressure.
    run(10, 0, 0, c0);
    chk("stream_first_cycle", 64'(first_pop), 64'(c0 + 4));
    chk("stream_last_cycle", 64'(last_pop), 64'(c0 + 13));

    // Stream with a 6-cycle downstream stall.
    lat_mode = 1'b0;
    run(10, 3, 6, c0);

    // Reset with three operations in flight.
    lat_mode = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; sub = 1'b0; b = 32'd1;
    for (int k = 0; k < 3; k++) begin
      a = W'(k + 10);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'(0));
    chk("async_reset_S", 64'(S), 64'(0));
    sb.delete();
    held = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pops = 0;
    send(32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
    drain();
    for (int k = 0; k < 10; k++) step();
    chk("post_reset_outputs", 64'(pops), 64'(1));

    // Random traffic with random backpressure.
    lat_mode = 1'b0;
    for (int k = 0; k < 120; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = $urandom;
      sub       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
